// File: rtl/decim_pkg.sv
// rtl/decim_pkg.sv - shared sample type and log2 helper for the decimating output FIFO
package decim_pkg;

  localparam int DW = 8;

  typedef logic [DW-1:0] sample_t;

  // Only ever called on powers of two, where ceil-log2 is exact.
  function automatic int log2_pow2(input int v);
    return $clog2(v);
  endfunction

endpackage

// File: rtl/decim_fifo_if.sv
// rtl/decim_fifo_if.sv - sample input and valid/ready output handshake of decim_fifo
interface decim_fifo_if;
  import decim_pkg::*;

  sample_t in_data;
  logic    in_en;
  sample_t out_data;
  logic    out_valid;
  logic    out_ready;

  modport master (
    output in_data, in_en, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  in_data, in_en, out_ready,
    output out_data, out_valid
  );

endinterface

// File: rtl/decim_fifo_sync_fifo.sv
// rtl/decim_fifo_sync_fifo.sv - circular sample buffer with explicit level and sticky drop flag
module sync_fifo
  import decim_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  sample_t                  push_data,
  input  logic                     pop_ready,
  output sample_t                  head_data,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int AW = log2_pow2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  sample_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          pop;
  logic          wr_en;
  logic          drop;

  assign full       = (level == FULL_LVL);
  assign empty      = (level == '0);
  assign pop        = !empty && pop_ready;
  // A pop in the same cycle frees the slot the push needs, so full alone does not drop.
  assign wr_en      = push && (!full || pop);
  assign drop       = push && full && !pop;

  assign head_valid = !empty;
  assign head_data  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level <= level + (AW+1)'(wr_en) - (AW+1)'(pop);
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/decim_fifo.sv
// rtl/decim_fifo.sv - decimate-by-DECIM stage feeding a small FIFO; DECIM_AVG_EN selects block average over sample pick
module decim_fifo
  import decim_pkg::*;
#(
  parameter int DECIM = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  decim_fifo_if.slave            bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int L = log2_pow2(DECIM);
  localparam logic [L-1:0] PH_LAST = L'(DECIM - 1);

  logic [L-1:0] phase;
  logic         last;
  sample_t      result;

  assign last = bus.in_en && (phase == PH_LAST);

  // DECIM is a power of two, so the natural wrap returns phase to 0 after the last sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
    end else if (bus.in_en) begin
      phase <= phase + L'(1);
    end
  end

`ifdef DECIM_AVG_EN
  logic [DW+L-1:0] acc;
  logic [DW+L-1:0] sum;

  assign sum    = acc + (DW+L)'(bus.in_data);
  assign result = sum[DW+L-1:L];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (bus.in_en) begin
      acc <= last ? '0 : sum;
    end
  end
`else
  assign result = bus.in_data;
`endif

  sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (last),
    .push_data  (result),
    .pop_ready  (bus.out_ready),
    .head_data  (bus.out_data),
    .head_valid (bus.out_valid),
    .level      (level),
    .overflow   (overflow)
  );

endmodule

// File: tb/tb_decim_fifo.sv
// tb/tb_decim_fifo.sv - directed self-checking bench for decim_fifo (DECIM=4, DEPTH=4)
module tb_decim_fifo;
  import decim_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] level;
  logic       overflow;
  int         total = 0;
  int         bad = 0;

`ifdef DECIM_AVG_EN
  localparam logic [7:0] EXP_BLOCK = 8'd25;
`else
  localparam logic [7:0] EXP_BLOCK = 8'd40;
`endif

  decim_fifo_if bus ();

  decim_fifo #(.DECIM(4), .DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .level    (level),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    bus.in_en   = 1'b1;
    bus.in_data = d;
    step();
    bus.in_en   = 1'b0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    bus.in_en = 1'b0;
    step();
    rst       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) begin
      bus.in_en     = 1'($urandom);
      bus.in_data   = 8'($urandom);
      bus.out_ready = 1'($urandom);
      step();
    end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0d want=0", bus.out_valid); end
    total++; if (bus.out_data !== 8'd0) begin bad++; $display("FAIL reset_data got=%0d want=0", bus.out_data); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0d want=0", overflow); end
    rst = 1'b0;
    bus.in_en = 1'b0;
    bus.out_ready = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [7:0] s [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid[%0d] got=%0d want=0", i, bus.out_valid); end
      send(s[i]);
    end
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0d want=1", bus.out_valid); end
    total++; if (bus.out_data !== EXP_BLOCK) begin bad++; $display("FAIL basic_data got=%0d want=%0d", bus.out_data, EXP_BLOCK); end
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL basic_after_valid got=%0d want=0", bus.out_valid); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL basic_after_level got=%0d want=0", level); end
  endtask

  task automatic test_gaps();
    logic       en [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] d  [9] = '{8'd10, 8'd99, 8'd7, 8'd20, 8'd255, 8'd30, 8'd1, 8'd3, 8'd40};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL gaps_early_valid[%0d] got=%0d want=0", i, bus.out_valid); end
      bus.in_en   = en[i];
      bus.in_data = d[i];
      step();
    end
    bus.in_en   = 1'b0;
    bus.in_data = 8'hA5;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL gaps_valid got=%0d want=1", bus.out_valid); end
    total++; if (bus.out_data !== EXP_BLOCK) begin bad++; $display("FAIL gaps_data got=%0d want=%0d", bus.out_data, EXP_BLOCK); end
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL gaps_after_valid got=%0d want=0", bus.out_valid); end
  endtask

  task automatic test_overflow();
    bus.out_ready = 1'b0;
    repeat (16) send(8'd255);
    total++; if (level !== 3'd4) begin bad++; $display("FAIL ovf_level4 got=%0d want=4", level); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_not_yet got=%0d want=0", overflow); end
    repeat (4) send(8'd255);
    total++; if (level !== 3'd4) begin bad++; $display("FAIL ovf_level5 got=%0d want=4", level); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0d want=1", overflow); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd255) begin bad++; $display("FAIL ovf_drain[%0d] got valid=%0d data=%0d want valid=1 data=255", i, bus.out_valid, bus.out_data); end
      step();
    end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL ovf_drained_level got=%0d want=0", level); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0d want=1", overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_q [4] = '{8'd2, 8'd3, 8'd4, 8'd9};
    do_reset();
    bus.out_ready = 1'b0;
    for (int v = 1; v <= 4; v++) repeat (4) send(8'(v));
    total++; if (level !== 3'd4) begin bad++; $display("FAIL fpp_prefill_level got=%0d want=4", level); end
    repeat (3) send(8'd9);
    bus.out_ready = 1'b1;
    send(8'd9);
    bus.out_ready = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fpp_overflow got=%0d want=0", overflow); end
    total++; if (level !== 3'd4) begin bad++; $display("FAIL fpp_level got=%0d want=4", level); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_q[i]) begin bad++; $display("FAIL fpp_drain[%0d] got valid=%0d data=%0d want valid=1 data=%0d", i, bus.out_valid, bus.out_data, exp_q[i]); end
      step();
    end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL fpp_empty got=%0d want=0", bus.out_valid); end
  endtask

  task automatic test_reset_mid_block();
    bus.out_ready = 1'b1;
    send(8'd100);
    send(8'd100);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rmb_early_valid[%0d] got=%0d want=0", i, bus.out_valid); end
      send(8'd8);
    end
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL rmb_valid got=%0d want=1", bus.out_valid); end
    total++; if (bus.out_data !== 8'd8) begin bad++; $display("FAIL rmb_data got=%0d want=8", bus.out_data); end
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rmb_after_valid got=%0d want=0", bus.out_valid); end
  endtask

  initial begin
    bus.in_en     = 1'b0;
    bus.in_data   = 8'd0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_gaps();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_block();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
